// File: rtl/digit_serial_addsub_pkg.sv
// digit_serial_addsub_pkg: state encoding and parameter helpers shared by the digit-serial add/sub
package digit_serial_addsub_pkg;
  typedef enum logic {IDLE, RUN} state_t;
  function automatic int ndig(input int width, input int digit);
    return width / digit;
  endfunction
  function automatic int cnt_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  function automatic bit legal(input int width, input int digit);
    return digit >= 1 && digit <= width && width % digit == 0;
  endfunction
endpackage

// File: rtl/digit_serial_addsub_if.sv
// digit_serial_addsub_if: start/busy/done handshake with operand and result bus
interface digit_serial_addsub_if #(parameter int WIDTH = 16);
  logic start, M, busy, done, Co, OV;
  logic [WIDTH-1:0] A, B, S;
  modport master(output start, A, B, M, input busy, done, S, Co, OV);
  modport slave(input start, A, B, M, output busy, done, S, Co, OV);
endinterface

// File: rtl/addsub_digit.sv
// addsub_digit: combinational DIGIT-bit ripple slice; b_d arrives already inverted for subtract
module addsub_digit #(parameter int DIGIT = 4) (
  input  logic [DIGIT-1:0] a_d,
  input  logic [DIGIT-1:0] b_d,
  input  logic             cin,
  output logic [DIGIT-1:0] s_d,
  output logic             cout,
  output logic             c_msb_in
);
  logic [DIGIT:0] c;
  assign c[0] = cin;
  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    assign s_d[i] = a_d[i] ^ b_d[i] ^ c[i];
    assign c[i+1] = (a_d[i] & b_d[i]) | (c[i] & (a_d[i] ^ b_d[i]));
  end
  assign cout = c[DIGIT];
  assign c_msb_in = c[DIGIT-1];
endmodule

// File: rtl/digit_serial_addsub.sv
// digit_serial_addsub: two's-complement add/sub computing DIGIT bits per clock over WIDTH/DIGIT cycles
module digit_serial_addsub
  import digit_serial_addsub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  digit_serial_addsub_if.slave bus
);
  localparam int NDIG = ndig(WIDTH, DIGIT);
  localparam int CW = cnt_w(NDIG);
  if (!legal(WIDTH, DIGIT)) begin : g_bad
    $error("digit_serial_addsub: WIDTH must be a positive multiple of DIGIT");
  end
  state_t state, state_n;
  logic [WIDTH-1:0] a_r, b_r;
  logic c_r, cout, c_msb_in, last;
  logic [CW-1:0] k;
  logic [DIGIT-1:0] s_d;
  addsub_digit #(.DIGIT(DIGIT)) u_slice (
    .a_d(a_r[k*DIGIT +: DIGIT]),
    .b_d(b_r[k*DIGIT +: DIGIT]),
    .cin(c_r),
    .s_d(s_d),
    .cout(cout),
    .c_msb_in(c_msb_in)
  );
  assign last = k == CW'(NDIG - 1);
  assign bus.busy = state == RUN;
  always_comb state_n = state == IDLE ? (bus.start ? RUN : IDLE) : (last ? IDLE : RUN);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r <= '0;
      b_r <= '0;
      c_r <= 1'b0;
      k <= '0;
      bus.S <= '0;
      bus.Co <= 1'b0;
      bus.OV <= 1'b0;
      bus.done <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      if (state == IDLE && bus.start) begin
        a_r <= bus.A;
        b_r <= bus.B ^ {WIDTH{bus.M}};
        c_r <= bus.M;
        k <= '0;
      end else if (state == RUN) begin
        bus.S[k*DIGIT +: DIGIT] <= s_d;
        c_r <= cout;
        k <= last ? '0 : k + 1'b1;
        if (last) begin
          bus.Co <= cout;
          bus.OV <= c_msb_in ^ cout;
          bus.done <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_digit_serial_addsub.sv
// tb_digit_serial_addsub: directed and random checks of three DIGIT configurations against a wide-add model
module tb_digit_serial_addsub;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic [15:0] a, b;
  logic m;
  logic [2:0] st;
  int sel;
  digit_serial_addsub_if #(16) b4(), b16(), b1();
  assign b4.A = a;  assign b4.B = b;  assign b4.M = m;  assign b4.start = st[0];
  assign b16.A = a; assign b16.B = b; assign b16.M = m; assign b16.start = st[1];
  assign b1.A = a;  assign b1.B = b;  assign b1.M = m;  assign b1.start = st[2];
  digit_serial_addsub #(.WIDTH(16), .DIGIT(4))  u4  (.clk(clk), .rst_n(rst_n), .bus(b4));
  digit_serial_addsub #(.WIDTH(16), .DIGIT(16)) u16 (.clk(clk), .rst_n(rst_n), .bus(b16));
  digit_serial_addsub #(.WIDTH(16), .DIGIT(1))  u1  (.clk(clk), .rst_n(rst_n), .bus(b1));
  logic sdone, sbusy, sco, sov;
  logic [15:0] ss;
  always_comb begin
    sdone = sel == 0 ? b4.done : sel == 1 ? b16.done : b1.done;
    sbusy = sel == 0 ? b4.busy : sel == 1 ? b16.busy : b1.busy;
    sco = sel == 0 ? b4.Co : sel == 1 ? b16.Co : b1.Co;
    sov = sel == 0 ? b4.OV : sel == 1 ? b16.OV : b1.OV;
    ss = sel == 0 ? b4.S : sel == 1 ? b16.S : b1.S;
  end
  int checks = 0, passed = 0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask
  task automatic ref_model(input logic [15:0] x, y, input logic mm, output logic [15:0] s, output logic co, ov);
    logic [16:0] sum;
    sum = {1'b0, x} + {1'b0, mm ? ~y : y} + 17'(mm);
    s = sum[15:0];
    co = sum[16];
    ov = (mm ? x[15] != y[15] : x[15] == y[15]) && s[15] != x[15];
  endtask
  task automatic launch(input int which, input logic [15:0] x, y, input logic mm);
    sel = which; a = x; b = y; m = mm;
    st = '0; st[which] = 1'b1;
    @(posedge clk); #1 st = '0;
  endtask
  task automatic await(output int lat, output int bc);
    lat = 0;
    bc = sbusy ? 1 : 0;
    while (!sdone && lat < 40) begin
      @(posedge clk); #1 lat++;
      if (!sdone && sbusy) bc++;
    end
  endtask
  task automatic op(input int which, input logic [15:0] x, y, input logic mm, input int nd, input string tag, output int bc);
    logic [15:0] es;
    logic eco, eov;
    int lat;
    ref_model(x, y, mm, es, eco, eov);
    launch(which, x, y, mm);
    await(lat, bc);
    chk({tag, " latency"}, lat, nd);
    chk({tag, " S"}, ss, es);
    chk({tag, " Co"}, sco, eco);
    chk({tag, " OV"}, sov, eov);
  endtask
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int bc, lat, seen;
    sel = 0; st = '0; a = '0; b = '0; m = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", sbusy, 0);
    chk("reset done", sdone, 0);
    chk("reset S", ss, 0);
    chk("reset Co", sco, 0);
    chk("reset OV", sov, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    op(0, 16'h1234, 16'h0FCD, 1'b0, 4, "add", bc);
    chk("add S const", ss, 16'h2201);
    chk("add busy cycles", bc, 4);
    op(0, 16'h0005, 16'h0007, 1'b1, 4, "sub borrow", bc);
    chk("sub S const", ss, 16'hFFFE);
    chk("sub Co const", sco, 0);
    op(0, 16'h7FFF, 16'h0001, 1'b0, 4, "ovf add", bc);
    chk("ovf add S const", ss, 16'h8000);
    chk("ovf add OV const", sov, 1);
    op(0, 16'h8000, 16'h0001, 1'b1, 4, "ovf sub", bc);
    chk("ovf sub S const", ss, 16'h7FFF);
    chk("ovf sub Co const", sco, 1);
    chk("ovf sub OV const", sov, 1);
    launch(0, 16'h1111, 16'h2222, 1'b0);
    @(posedge clk); #1 rst_n = 1'b0;
    #1;
    chk("midrst busy", sbusy, 0);
    chk("midrst done", sdone, 0);
    chk("midrst S", ss, 0);
    chk("midrst Co", sco, 0);
    chk("midrst OV", sov, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    seen = 0;
    repeat (6) begin
      @(posedge clk); #1 if (sdone) seen++;
    end
    chk("midrst no done", seen, 0);
    op(0, 16'h1111, 16'h2222, 1'b0, 4, "post reset", bc);
    chk("post reset S const", ss, 16'h3333);
    launch(0, 16'h0001, 16'h0002, 1'b0);
    @(posedge clk); #1;
    a = 16'h0F0F; b = 16'h1111; m = 1'b1; st[0] = 1'b1;
    @(posedge clk); #1 st = '0;
    await(lat, bc);
    chk("ignored start latency", lat, 2);
    chk("ignored start S", ss, 16'h0003);
    chk("ignored start Co", sco, 0);
    op(0, 16'h0100, 16'h0023, 1'b0, 4, "back to back", bc);
    chk("back to back S const", ss, 16'h0123);
    for (int i = 0; i < 1000; i++)
      op(1, 16'($urandom), 16'($urandom), 1'($urandom), 1, "digit16", bc);
    for (int i = 0; i < 1000; i++)
      op(2, 16'($urandom), 16'($urandom), 1'($urandom), 16, "digit1", bc);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
